// File: rtl/systolic_mac_array.sv
// Output-stationary DEPTH x DEPTH systolic multiply-accumulate grid.
// Row i takes the skewed serial A-row stream on its left edge and column j
// takes the skewed B-column stream on its top edge. Operands ripple right
// and down one PE per shift, while each PE accumulates in place. A single
// load/shift sequence on the shared ctl bus computes C = A x B.
module systolic_mac_array #(
   parameter int DEPTH    = 8,
   parameter int BITS     = 8,
   parameter int ACC_BITS = 2*BITS + $clog2(DEPTH)
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [1:0]                           ctl,
   input  logic [DEPTH-1:0][BITS-1:0]           a_in,
   input  logic [DEPTH-1:0][BITS-1:0]           b_in,
   output logic [DEPTH*DEPTH-1:0][ACC_BITS-1:0] c_out,
   output logic                                 busy,
   output logic                                 done
);

   localparam int CNT_W = $clog2(3*DEPTH-1);
   // Final useful step; the shift that ends it completes the product.
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(3*DEPTH-3);

   localparam logic [1:0] CTL_LOAD  = 2'b01;
   localparam logic [1:0] CTL_SHIFT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             clear;
   logic             shift_en;

   // Forwarding registers between neighbouring PEs. The last column's a
   // and the last row's b have no consumer, so those positions are omitted.
   logic [DEPTH*(DEPTH-1)*BITS-1:0] a_pipe;
   logic [(DEPTH-1)*DEPTH*BITS-1:0] b_pipe;

   // Control state, step counter and the registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Load wins from any state (aborting a run); shifts only count in RUN.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      clear    = 1'b0;
      shift_en = 1'b0;
      if (ctl == CTL_LOAD) begin
         clear   = 1'b1;
         step_d  = '0;
         state_d = ST_RUN;
      end else if ((ctl == CTL_SHIFT) && (state_q == ST_RUN)) begin
         shift_en = 1'b1;
         step_d   = step_q + CNT_W'(1);
         if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
         end
      end
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   assign busy = busy_q;
   assign done = done_q;

   genvar gi, gj;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_row
         for (gj = 0; gj < DEPTH; gj++) begin : g_col
            logic signed [BITS-1:0]     a_w;
            logic signed [BITS-1:0]     b_w;
            logic signed [2*BITS-1:0]   prod_w;
            logic signed [ACC_BITS-1:0] prod_ext_w;
            logic signed [ACC_BITS-1:0] acc_q;

            // Left-edge PEs take the A stream; others take the left neighbour.
            if (gj == 0) begin : g_a_edge
               assign a_w = a_in[gi];
            end else begin : g_a_inner
               assign a_w = a_pipe[(gi*(DEPTH-1)+gj-1)*BITS +: BITS];
            end

            // Top-edge PEs take the B stream; others take the upper neighbour.
            if (gi == 0) begin : g_b_edge
               assign b_w = b_in[gj];
            end else begin : g_b_inner
               assign b_w = b_pipe[((gi-1)*DEPTH+gj)*BITS +: BITS];
            end

            // Full-width signed product, sign-extended to the accumulator.
            assign prod_w     = a_w * b_w;
            assign prod_ext_w = ACC_BITS'(prod_w);

            // Accumulate in place; wraps modulo 2^ACC_BITS.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  acc_q <= '0;
               end else if (clear) begin
                  acc_q <= '0;
               end else if (shift_en) begin
                  acc_q <= acc_q + prod_ext_w;
               end
            end

            assign c_out[gi*DEPTH+gj] = acc_q;

            if (gj < DEPTH-1) begin : g_a_fwd
               logic signed [BITS-1:0] a_q;
               // Pass A rightwards one PE per shift.
               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n) begin
                     a_q <= '0;
                  end else if (clear) begin
                     a_q <= '0;
                  end else if (shift_en) begin
                     a_q <= a_w;
                  end
               end
               assign a_pipe[(gi*(DEPTH-1)+gj)*BITS +: BITS] = a_q;
            end

            if (gi < DEPTH-1) begin : g_b_fwd
               logic signed [BITS-1:0] b_q;
               // Pass B downwards one PE per shift.
               always_ff @(posedge clk or negedge rst_n) begin
                  if (!rst_n) begin
                     b_q <= '0;
                  end else if (clear) begin
                     b_q <= '0;
                  end else if (shift_en) begin
                     b_q <= b_w;
                  end
               end
               assign b_pipe[(gi*DEPTH+gj)*BITS +: BITS] = b_q;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_systolic_mac_array.sv
// Scoreboard bench for a 2x2 systolic_mac_array: stimulus pushes the
// hand-computed product at load time, a monitor pops it when done rises.
module tb_systolic_mac_array;

   localparam int N   = 2;
   localparam int BW  = 8;
   localparam int ACC = 17;

   logic                   clk;
   logic                   rst_n;
   logic [1:0]             ctl;
   logic [N-1:0][BW-1:0]   a_in;
   logic [N-1:0][BW-1:0]   b_in;
   logic [N*N-1:0][ACC-1:0] c_out;
   logic                   busy;
   logic                   done;

   systolic_mac_array #(.DEPTH(N), .BITS(BW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctl   (ctl),
      .a_in  (a_in),
      .b_in  (b_in),
      .c_out (c_out),
      .busy  (busy),
      .done  (done)
   );

   typedef struct {
      int c0;
      int c1;
      int c2;
      int c3;
   } exp_t;

   exp_t exp_q[$];
   int   ma [N][N];
   int   mb [N][N];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   logic done_prev = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint req);
      chk_cnt++;
      if (act == req) pass_cnt++;
      else $display("FAIL %s: got %0d, required %0d", nm, act, req);
   endtask

   function automatic longint cval(input int k);
      return longint'($signed(c_out[k]));
   endfunction

   task automatic set_mats(input int a00, input int a01, input int a10, input int a11,
                           input int b00, input int b01, input int b10, input int b11);
      ma[0][0] = a00; ma[0][1] = a01; ma[1][0] = a10; ma[1][1] = a11;
      mb[0][0] = b00; mb[0][1] = b01; mb[1][0] = b10; mb[1][1] = b11;
   endtask

   // Model of the transpose FIFO outputs: row/column index = delay.
   task automatic set_streams(input int s);
      for (int i = 0; i < N; i++) begin
         int k;
         k = s - i;
         a_in[i] = (k >= 0 && k < N) ? BW'(ma[i][k]) : '0;
         b_in[i] = (k >= 0 && k < N) ? BW'(mb[k][i]) : '0;
      end
   endtask

   task automatic tick(input logic [1:0] c);
      ctl = c;
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int e0, input int e1, input int e2, input int e3);
      exp_t e;
      e.c0 = e0; e.c1 = e1; e.c2 = e2; e.c3 = e3;
      exp_q.push_back(e);
   endtask

   // Load, four shifts (optionally with hold cycles interleaved), one hold.
   task automatic run_case(input int e0, input int e1, input int e2, input int e3,
                           input bit holds);
      push_exp(e0, e1, e2, e3);
      set_streams(0);
      tick(2'b01);
      check("busy_after_load", busy, 1);
      check("done_after_load", done, 0);
      for (int s = 0; s < 4; s++) begin
         set_streams(s);
         tick(2'b10);
         if (s < 3) begin
            check("busy_mid_run", busy, 1);
            check("done_mid_run", done, 0);
         end else begin
            check("busy_after_last", busy, 0);
            check("done_after_last", done, 1);
         end
         if (holds && s == 1) begin
            for (int h = 0; h < 3; h++) begin
               set_streams(2);
               tick(2'b00);
               check("busy_hold00", busy, 1);
               check("done_hold00", done, 0);
            end
         end
         if (holds && s == 2) begin
            set_streams(3);
            tick(2'b11);
            check("busy_hold11", busy, 1);
            check("done_hold11", done, 0);
         end
      end
      set_streams(4);
      tick(2'b00);
   endtask

   // Monitor: pop and compare whenever done rises; exclusivity every cycle.
   always @(negedge clk) begin
      exp_t e;
      check("busy_done_excl", longint'(busy && done), 0);
      if (done && !done_prev) begin
         check("sb_pending", longint'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("c00", cval(0), e.c0);
            check("c01", cval(1), e.c1);
            check("c10", cval(2), e.c2);
            check("c11", cval(3), e.c3);
            $display("txn: c_out={%0d,%0d,%0d,%0d}", cval(0), cval(1), cval(2), cval(3));
         end
      end
      done_prev = done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      ctl   = 2'b00;
      a_in  = '0;
      b_in  = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < N*N; k++) check("reset_c", cval(k), 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      rst_n = 1'b1;
      tick(2'b00);

      // Basic product
      set_mats(1, 2, 3, 4, 5, 6, 7, 8);
      run_case(19, 22, 43, 50, 1'b0);

      // Extra shifts after done are ignored
      a_in = {8'd3, 8'd3};
      b_in = {8'd5, 8'd5};
      for (int k = 0; k < 5; k++) begin
         tick(2'b10);
         check("done_stays", done, 1);
         check("busy_stays_low", busy, 0);
      end
      check("frozen_c00", cval(0), 19);
      check("frozen_c01", cval(1), 22);
      check("frozen_c10", cval(2), 43);
      check("frozen_c11", cval(3), 50);

      // Identity times B
      set_mats(1, 0, 0, 1, 5, 6, 7, 8);
      run_case(5, 6, 7, 8, 1'b0);

      // Extreme operands
      set_mats(-128, -128, -128, -128, -128, -128, -128, -128);
      run_case(32768, 32768, 32768, 32768, 1'b0);
      set_mats(127, 127, 127, 127, -128, -128, -128, -128);
      run_case(-32512, -32512, -32512, -32512, 1'b0);

      // Holds interleaved within the run
      set_mats(1, 2, 3, 4, 5, 6, 7, 8);
      run_case(19, 22, 43, 50, 1'b1);

      // Abort by reloading mid-run
      set_streams(0);
      tick(2'b01);
      for (int s = 0; s < 2; s++) begin
         set_streams(s);
         tick(2'b10);
      end
      set_mats(2, 0, 0, 2, 1, 1, 1, 1);
      run_case(2, 2, 2, 2, 1'b0);

      // Asynchronous reset mid-run
      set_mats(1, 2, 3, 4, 5, 6, 7, 8);
      set_streams(0);
      tick(2'b01);
      for (int s = 0; s < 2; s++) begin
         set_streams(s);
         tick(2'b10);
      end
      #2;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < N*N; k++) check("async_rst_c", cval(k), 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      a_in = {8'd3, 8'd3};
      b_in = {8'd5, 8'd5};
      for (int k = 0; k < 3; k++) begin
         tick(2'b10);
         check("idle_shift_busy", busy, 0);
         check("idle_shift_done", done, 0);
         check("idle_shift_c00", cval(0), 0);
      end

      // Normal run after reset
      run_case(19, 22, 43, 50, 1'b0);
      repeat (2) tick(2'b00);
      check("sb_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
